// File: rtl/huff_pkg.sv
// Shared constants, widths and stager state encoding for the Huffman
// bit shifter (byte stager + MSB-aligned code window).
package huff_pkg;

  localparam int MAX_CODE  = 9;  // code window width / longest Huffman code
  localparam int CHUNK_MAX = 4;  // most bits handed to the decoder at once
  localparam int BITCNT_W  = 4;  // holds 0..MAX_CODE and stage counts 0..8
  localparam int LEN_W     = 3;  // holds chunk lengths 0..CHUNK_MAX

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } stage_state_e;

  // Chunk length: limited by the chunk width, the bits left in the stage
  // and the free room in the code window.
  function automatic logic [LEN_W-1:0] chunk_len(
    input logic [BITCNT_W-1:0] stage_cnt,
    input logic [BITCNT_W-1:0] room
  );
    logic [BITCNT_W-1:0] len;
    len = BITCNT_W'(CHUNK_MAX);
    if (stage_cnt < len) len = stage_cnt;
    if (room < len) len = room;
    return len[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/huff_bit_shifter_if.sv
// Compressed byte stream handshake into the Huffman bit shifter.
interface huff_bit_shifter_if;

  logic [7:0] s_byte;
  logic       s_byte_valid;
  logic       s_last;
  logic [2:0] s_pad;
  logic       s_byte_ready;

  // Byte source side
  modport master (
    output s_byte, s_byte_valid, s_last, s_pad,
    input  s_byte_ready
  );

  // Byte sink side (the shifter)
  modport slave (
    input  s_byte, s_byte_valid, s_last, s_pad,
    output s_byte_ready
  );

endinterface

// File: rtl/huff_byte_stager.sv
// Byte staging register: accepts compressed bytes, trims the padding of the
// final byte and offers its bits MSB-first as 1..4 bit chunks.
module huff_byte_stager
  import huff_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  huff_bit_shifter_if.slave    s_if,
  input  logic                 load_bits,
  input  logic [BITCNT_W-1:0]  bit_count,
  input  logic                 done_set,
  output logic [CHUNK_MAX-1:0] in_data,
  output logic [LEN_W-1:0]     in_len,
  output logic                 svalid,
  output logic [BITCNT_W-1:0]  stage_cnt,
  output logic                 last_seen
);

  logic [7:0]          stage_reg, stage_next;
  logic [BITCNT_W-1:0] stage_cnt_reg, stage_cnt_next;
  stage_state_e        state_reg, state_next;
  logic [LEN_W-1:0]    consume;
  logic                drained_by_load;
  logic                accept;

  assign stage_cnt = stage_cnt_reg;
  // The final byte has been taken once the FSM leaves EMPTY/HOLD.
  assign last_seen = (state_reg == ST_DRAIN) || (state_reg == ST_DONE);

  // Chunk presentation from registered state; the top bits of the stage are
  // right-justified so the newest bit lands in in_data[0].
  always_comb begin
    in_len  = chunk_len(stage_cnt_reg, BITCNT_W'(MAX_CODE) - bit_count);
    in_data = stage_reg[7 -: CHUNK_MAX] >> (LEN_W'(CHUNK_MAX) - in_len);
    svalid  = (in_len != '0);
  end

  assign consume         = load_bits ? in_len : '0;
  assign drained_by_load = load_bits && (stage_cnt_reg != '0) &&
                           ({1'b0, in_len} == stage_cnt_reg);
  // A byte may replace the stage in the same cycle its last bits are loaded.
  assign s_if.s_byte_ready = !reset && !last_seen &&
                             ((stage_cnt_reg == '0) || drained_by_load);
  assign accept = s_if.s_byte_valid && s_if.s_byte_ready;

  // Stage datapath and stager FSM next state.
  always_comb begin
    stage_next     = stage_reg << consume;
    stage_cnt_next = stage_cnt_reg - {1'b0, consume};
    if (accept) begin
      stage_next     = s_if.s_byte;
      stage_cnt_next = s_if.s_last ? (4'd8 - {1'b0, s_if.s_pad}) : 4'd8;
    end

    state_next = state_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (accept) state_next = s_if.s_last ? ST_DRAIN : ST_HOLD;
      end
      ST_HOLD: begin
        if (accept)                     state_next = s_if.s_last ? ST_DRAIN : ST_HOLD;
        else if (stage_cnt_next == '0)  state_next = ST_EMPTY;
      end
      ST_DRAIN: begin
        if (done_set) state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_EMPTY;
    endcase
  end

  // Stage registers and FSM state.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_reg     <= '0;
      stage_cnt_reg <= '0;
      state_reg     <= ST_EMPTY;
    end else begin
      stage_reg     <= stage_next;
      stage_cnt_reg <= stage_cnt_next;
      state_reg     <= state_next;
    end
  end

endmodule

// File: rtl/huff_bit_shifter.sv
// Huffman decoder front end: owns the MSB-aligned code window. Chunks from
// the byte stager are appended on load_bits; matched codes are removed on
// shift_en. A same-cycle shift is applied before the append.
module huff_bit_shifter
  import huff_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  huff_bit_shifter_if.slave    s_if,
  output logic                 svalid,
  output logic [CHUNK_MAX-1:0] in_data,
  output logic [LEN_W-1:0]     in_len,
  input  logic                 aready,
  input  logic                 load_bits,
  input  logic                 shift_en,
  input  logic [3:0]           shift_len,
  output logic [MAX_CODE-1:0]  shift_buf,
  output logic [BITCNT_W-1:0]  bit_count,
  output logic                 stream_done,
  output logic                 err
);

  logic [MAX_CODE-1:0] shift_buf_reg, shift_buf_next;
  logic [BITCNT_W-1:0] bit_count_reg, bit_count_next;
  logic                err_reg, err_next;
  logic                stream_done_reg, stream_done_next;
  logic [BITCNT_W-1:0] stage_cnt;
  logic                last_seen;
  logic                done_set;
  logic [MAX_CODE-1:0] buf_sh;
  logic [BITCNT_W-1:0] cnt_sh;
  logic [BITCNT_W-1:0] place_amt;
  logic                shift_err, load_err;

  // The decoder's request line carries no control meaning here.
  logic unused_aready;
  assign unused_aready = aready;

  assign shift_buf   = shift_buf_reg;
  assign bit_count   = bit_count_reg;
  assign err         = err_reg;
  assign stream_done = stream_done_reg;

  assign done_set = last_seen && (stage_cnt == '0) && (bit_count_reg == '0);

  huff_byte_stager u_stager (
    .clk       (clk),
    .reset     (reset),
    .s_if      (s_if),
    .load_bits (load_bits),
    .bit_count (bit_count_reg),
    .done_set  (done_set),
    .in_data   (in_data),
    .in_len    (in_len),
    .svalid    (svalid),
    .stage_cnt (stage_cnt),
    .last_seen (last_seen)
  );

  // Window update: shift (with underflow clamp) first, then append the chunk
  // just below the surviving bits. in_len came from the pre-shift count, so
  // the append always fits.
  always_comb begin
    buf_sh    = shift_buf_reg;
    cnt_sh    = bit_count_reg;
    shift_err = 1'b0;
    if (shift_en && (shift_len != '0)) begin
      if (shift_len > bit_count_reg) begin
        shift_err = 1'b1;
        buf_sh    = '0;
        cnt_sh    = '0;
      end else begin
        buf_sh = shift_buf_reg << shift_len;
        cnt_sh = bit_count_reg - shift_len;
      end
    end

    shift_buf_next = buf_sh;
    bit_count_next = cnt_sh;
    load_err       = 1'b0;
    place_amt      = BITCNT_W'(MAX_CODE) - cnt_sh - {1'b0, in_len};
    if (load_bits) begin
      if (in_len == '0) begin
        load_err = 1'b1;
      end else begin
        shift_buf_next = buf_sh | (MAX_CODE'(in_data) << place_amt);
        bit_count_next = cnt_sh + {1'b0, in_len};
      end
    end

    err_next         = err_reg | shift_err | load_err;
    stream_done_next = stream_done_reg | done_set;
  end

  // Window, sticky error and end-of-stream registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_buf_reg   <= '0;
      bit_count_reg   <= '0;
      err_reg         <= 1'b0;
      stream_done_reg <= 1'b0;
    end else begin
      shift_buf_reg   <= shift_buf_next;
      bit_count_reg   <= bit_count_next;
      err_reg         <= err_next;
      stream_done_reg <= stream_done_next;
    end
  end

endmodule
